// File: rtl/nabp_mapper_pkg.sv
// Shared constants and FSM encoding for the NABP mapper sequencer and its accumulator.
package nabp_mapper_pkg;

  localparam int unsigned ANGLE_W = 9;
  localparam int unsigned LINE_W  = 7;
  localparam int unsigned ACCU_W  = 24;
  localparam int unsigned FRAC_W  = 12;
  localparam int unsigned ADDR_W  = ACCU_W - FRAC_W;
  localparam int unsigned LUT_LAT = 2;
  localparam int unsigned WAIT_W  = 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLookup = 3'd1,
    StLoad   = 3'd2,
    StStream = 3'd3,
    StNext   = 3'd4
  } mapper_state_e;

endpackage

// File: rtl/nabp_mapper_sequencer_if.sv
// Valid/ready beat channel from the mapper sequencer to the line buffer.
interface nabp_mapper_sequencer_if;
  import nabp_mapper_pkg::*;

  logic              map_valid;
  logic              map_ready;
  logic [ADDR_W-1:0] map_addr;
  logic              map_oob;
  logic [LINE_W-1:0] map_line;
  logic [ANGLE_W-1:0] map_angle;

  modport master (
    output map_valid, map_addr, map_oob, map_line, map_angle,
    input  map_ready
  );

  modport slave (
    input  map_valid, map_addr, map_oob, map_line, map_angle,
    output map_ready
  );

endinterface

// File: rtl/nabp_mapper_accu.sv
// Signed fixed-point mapping accumulator: loads init/base from the LUT, then steps by base.
module nabp_mapper_accu
  import nabp_mapper_pkg::*;
#(
  parameter int unsigned LINES = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     step,
  input  logic signed [ACCU_W-1:0] init,
  input  logic signed [ACCU_W-1:0] base,
  output logic [ADDR_W-1:0]        addr,
  output logic                     oob
);

  logic signed [ACCU_W-1:0] accu_q;
  logic signed [ACCU_W-1:0] base_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      accu_q <= '0;
      base_q <= '0;
    end else if (load) begin
      accu_q <= init;
      base_q <= base;
    end else if (step) begin
      // Wraps modulo 2**ACCU_W; no saturation.
      accu_q <= accu_q + base_q;
    end
  end

  always_comb begin
    addr = accu_q[ACCU_W-1:FRAC_W];
    oob  = accu_q[ACCU_W-1] | (32'(addr) >= LINES);
  end

endmodule

// File: rtl/nabp_mapper_sequencer.sv
// Sweeps mp_angle over [0, ANGLE_END), fetching LUT init/base per angle and streaming LINES beats.
module nabp_mapper_sequencer
  import nabp_mapper_pkg::*;
#(
  parameter int unsigned ANGLE_STEP = 1,
  parameter int unsigned ANGLE_END  = 180,
  parameter int unsigned LINES      = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [ANGLE_W-1:0]        mp_angle,
  output logic [LINE_W-1:0]         mp_line_cnt,
  input  logic signed [ACCU_W-1:0]  mp_accu_init,
  input  logic signed [ACCU_W-1:0]  mp_accu_base,
  nabp_mapper_sequencer_if.master   map
);

  mapper_state_e      state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic               accu_load, accu_step;
  logic               handshake, last_line, last_angle;

  assign handshake  = (state_q == StStream) && map.map_ready;
  assign last_line  = (line_q == LINE_W'(LINES - 1));
  assign last_angle = (32'(angle_q) + 32'(ANGLE_STEP)) >= 32'(ANGLE_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
      angle_q <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      angle_q <= angle_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    angle_d   = angle_q;
    line_d    = line_q;
    accu_load = 1'b0;
    accu_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLookup;
          angle_d = '0;
          wait_d  = WAIT_W'(LUT_LAT - 1);
        end
      end
      StLookup: begin
        if (wait_q == '0) state_d = StLoad;
        else              wait_d  = wait_q - 1'b1;
      end
      StLoad: begin
        accu_load = 1'b1;
        line_d    = '0;
        state_d   = StStream;
      end
      StStream: begin
        if (handshake) begin
          accu_step = 1'b1;
          line_d    = line_q + 1'b1;
          if (last_line) begin
            // Line returns to 0 so mp_line_cnt reads 0 outside STREAM.
            line_d  = '0;
            state_d = StNext;
          end
        end
      end
      StNext: begin
        if (last_angle) begin
          angle_d = '0;
          state_d = StIdle;
        end else begin
          angle_d = angle_q + ANGLE_W'(ANGLE_STEP);
          wait_d  = WAIT_W'(LUT_LAT - 1);
          state_d = StLookup;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  nabp_mapper_accu #(
    .LINES (LINES)
  ) u_accu (
    .clk   (clk),
    .reset (reset),
    .load  (accu_load),
    .step  (accu_step),
    .init  (mp_accu_init),
    .base  (mp_accu_base),
    .addr  (map.map_addr),
    .oob   (map.map_oob)
  );

  always_comb begin
    done          = (state_q == StNext) && last_angle;
    busy          = (state_q != StIdle) && !done;
    mp_angle      = angle_q;
    mp_line_cnt   = line_q;
    map.map_valid = (state_q == StStream);
    map.map_line  = line_q;
    map.map_angle = angle_q;
  end

endmodule

// File: tb/tb_nabp_mapper_sequencer.sv
// Randomised self-checking bench for nabp_mapper_sequencer with a latency-accurate LUT stand-in.
module tb_nabp_mapper_sequencer;

  localparam int LINES   = 128;
  localparam int ANGLES  = 180;
  localparam int LUT_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [8:0]  mp_angle;
  logic [6:0]  mp_line_cnt;
  logic [23:0] mp_accu_init;
  logic [23:0] mp_accu_base;

  int checks = 0;
  int errors = 0;

  // LUT stand-in: value derived from angle with LUT_LAT cycles of latency.
  int lut_init  = 0;
  int lut_base  = 0;
  int lut_scale = 0;
  logic [8:0] ang_d1 = '0;
  logic [8:0] ang_d2 = '0;

  nabp_mapper_sequencer_if m_if ();

  nabp_mapper_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .mp_angle     (mp_angle),
    .mp_line_cnt  (mp_line_cnt),
    .mp_accu_init (mp_accu_init),
    .mp_accu_base (mp_accu_base),
    .map          (m_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ang_d1 <= mp_angle;
    ang_d2 <= ang_d1;
  end

  assign mp_accu_init = 24'(lut_init + int'(ang_d2) * lut_scale);
  assign mp_accu_base = 24'(lut_base);

  // Accumulator value for a given angle/line: init(angle) + line*base, mod 2**24.
  function automatic logic [23:0] model_accu(input int angle, input int line);
    return 24'(lut_init + angle * lut_scale + line * lut_base);
  endfunction

  function automatic logic [12:0] model_beat(input int angle, input int line);
    logic [23:0] acc;
    acc = model_accu(angle, line);
    return {(acc[23] || (int'(acc[23:12]) >= LINES)), acc[23:12]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, m_if.map_valid, mp_angle, mp_line_cnt, m_if.map_addr, m_if.map_oob} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b valid=%b angle=%0d line=%0d addr=%h oob=%b, want all 0",
               busy, done, m_if.map_valid, mp_angle, mp_line_cnt, m_if.map_addr, m_if.map_oob);
    end
    // start and reset together: reset wins, block stays idle.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || m_if.map_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: busy=%b valid=%b, want 0 0", busy, m_if.map_valid);
    end
  endtask

  task automatic test_latency_basic();
    int lat;
    lut_init = 'h001000; lut_base = 'h000800; lut_scale = 0;
    m_if.map_ready = 1'b1;
    start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (m_if.map_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != LUT_LAT + 2) begin
      errors++;
      $display("FAIL first_valid_latency: got %0d cycles, want %0d", lat, LUT_LAT + 2);
    end
    for (int l = 0; l < LINES; l++) begin
      checks++;
      if (m_if.map_valid !== 1'b1 || m_if.map_line !== 7'(l) || mp_line_cnt !== 7'(l) ||
          m_if.map_addr !== 12'((l + 2) / 2) || m_if.map_oob !== 1'b0 || m_if.map_angle !== 9'd0) begin
        errors++;
        $display("FAIL basic_beat: line %0d valid=%b line=%0d addr=%0d oob=%b, want addr %0d oob 0",
                 l, m_if.map_valid, m_if.map_line, m_if.map_addr, m_if.map_oob, (l + 2) / 2);
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    int exp_angle, exp_line, beats;
    logic held, r;
    logic [33:0] prev;
    lut_init = 'h003000; lut_base = -'h000155; lut_scale = 'h2345;
    exp_angle = 0; exp_line = 0; beats = 0; held = 1'b0; prev = '0;
    start = 1'b1;
    for (int c = 0; c < 3000 && beats < 2 * LINES; c++) begin
      tick();
      if (c == 0) start = 1'b0;
      if (held) begin
        checks++;
        if ({m_if.map_valid, m_if.map_oob, m_if.map_addr, m_if.map_line, m_if.map_angle} !== prev) begin
          errors++;
          $display("FAIL stall_stable: outputs %h, want %h held",
                   {m_if.map_valid, m_if.map_oob, m_if.map_addr, m_if.map_line, m_if.map_angle}, prev);
        end
      end
      r = ($urandom_range(0, 99) < 60);
      m_if.map_ready = r;
      held = 1'b0;
      if (m_if.map_valid === 1'b1) begin
        if (r) begin
          checks++;
          if ({m_if.map_oob, m_if.map_addr} !== model_beat(exp_angle, exp_line) ||
              m_if.map_line !== 7'(exp_line) || m_if.map_angle !== 9'(exp_angle)) begin
            errors++;
            $display("FAIL bp_beat: angle=%0d line=%0d oob/addr=%h, want angle=%0d line=%0d oob/addr=%h",
                     m_if.map_angle, m_if.map_line, {m_if.map_oob, m_if.map_addr},
                     exp_angle, exp_line, model_beat(exp_angle, exp_line));
          end
          beats++;
          exp_line++;
          if (exp_line == LINES) begin
            exp_line = 0;
            exp_angle++;
          end
        end else begin
          held = 1'b1;
          prev = {m_if.map_valid, m_if.map_oob, m_if.map_addr, m_if.map_line, m_if.map_angle};
        end
      end
    end
    checks++;
    if (beats != 2 * LINES) begin
      errors++;
      $display("FAIL bp_beat_count: got %0d beats, want %0d", beats, 2 * LINES);
    end
    m_if.map_ready = 1'b1;
    do_reset();
  endtask

  task automatic test_stream_cases();
    int inits[3] = '{-'h002000, 'h07F000, 'h7FF000};
    int bases[3] = '{'h001000, 'h001000, 'h001000};
    int got;
    for (int k = 0; k < 3; k++) begin
      lut_init = inits[k]; lut_base = bases[k]; lut_scale = 0;
      m_if.map_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      got = 0;
      for (int c = 0; c < 200 && got < LINES; c++) begin
        if (m_if.map_valid === 1'b1) begin
          checks++;
          if ({m_if.map_oob, m_if.map_addr} !== model_beat(0, got) ||
              $isunknown({m_if.map_oob, m_if.map_addr})) begin
            errors++;
            $display("FAIL oob_wrap_case%0d: line %0d oob/addr=%h, want %h",
                     k, got, {m_if.map_oob, m_if.map_addr}, model_beat(0, got));
          end
          got++;
        end
        tick();
      end
      checks++;
      if (got != LINES) begin
        errors++;
        $display("FAIL oob_wrap_count%0d: got %0d beats, want %0d", k, got, LINES);
      end
      do_reset();
    end
  endtask

  task automatic test_full_sweep();
    int exp_angle, exp_line, beats, dones, done_cycle;
    lut_init = 'h000400; lut_base = 'h000080; lut_scale = 'h0123;
    m_if.map_ready = 1'b1;
    exp_angle = 0; exp_line = 0; beats = 0; dones = 0; done_cycle = -1;
    start = 1'b1;
    for (int c = 1; c <= 24000; c++) begin
      tick();
      start = (c % 5000 == 0) ? 1'b1 : 1'b0;  // ignored while busy
      if (m_if.map_valid === 1'b1) begin
        checks++;
        if ({m_if.map_oob, m_if.map_addr} !== model_beat(exp_angle, exp_line) ||
            m_if.map_line !== 7'(exp_line) || m_if.map_angle !== 9'(exp_angle)) begin
          errors++;
          $display("FAIL sweep_beat: angle=%0d line=%0d oob/addr=%h, want angle=%0d line=%0d oob/addr=%h",
                   m_if.map_angle, m_if.map_line, {m_if.map_oob, m_if.map_addr},
                   exp_angle, exp_line, model_beat(exp_angle, exp_line));
        end
        beats++;
        exp_line++;
        if (exp_line == LINES) begin
          exp_line = 0;
          exp_angle++;
        end
      end else if (mp_line_cnt !== 7'd0) begin
        checks++;
        errors++;
        $display("FAIL line_cnt_idle: got %0d, want 0", mp_line_cnt);
      end
      if (done === 1'b1) begin
        dones++;
        if (done_cycle < 0) done_cycle = c;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_with_done: busy=%b, want 0", busy);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (done_cycle != ANGLES * (LINES + 4)) begin
      errors++;
      $display("FAIL done_cycle: got %0d, want %0d", done_cycle, ANGLES * (LINES + 4));
    end
    checks++;
    if (dones != 1 || beats != ANGLES * LINES) begin
      errors++;
      $display("FAIL sweep_totals: dones=%0d beats=%0d, want 1 and %0d", dones, beats, ANGLES * LINES);
    end
    checks++;
    if (busy !== 1'b0 || mp_angle !== 9'd0) begin
      errors++;
      $display("FAIL sweep_end_idle: busy=%b angle=%0d, want 0 0", busy, mp_angle);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int found, lat;
    lut_init = 'h001000; lut_base = 'h000800; lut_scale = 0;
    m_if.map_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 6000; c++) begin
      if (m_if.map_valid === 1'b1 && m_if.map_angle === 9'd37) begin
        found = 1;
        break;
      end
      tick();
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL reach_angle37: got no beat of angle 37, want one");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (m_if.map_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mp_angle !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b done=%b angle=%0d, want 0 0 0 0",
               m_if.map_valid, busy, done, mp_angle);
    end
    start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (m_if.map_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != LUT_LAT + 2 || m_if.map_angle !== 9'd0 || m_if.map_line !== 7'd0) begin
      errors++;
      $display("FAIL restart: latency=%0d angle=%0d line=%0d, want %0d 0 0",
               lat, m_if.map_angle, m_if.map_line, LUT_LAT + 2);
    end
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    m_if.map_ready = 1'b1;
    test_reset();
    test_latency_basic();
    test_backpressure();
    test_stream_cases();
    test_full_sweep();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
